// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage core: per-stage stall/flush enables,
// next-PC redirect (deferred while a fetch is in flight) and a stall-cycle counter.
module hazard_ctrl #(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             ra1_d,
    input  logic [4:0]             ra2_d,
    input  logic                   use1_d,
    input  logic                   use2_d,
    input  logic                   ld_e,
    input  logic [4:0]             ld_dst_e,
    input  logic                   jump_d,
    input  logic [63:0]            pcsrc_d,
    input  logic                   ireq,
    input  logic                   idone,
    input  logic                   dreq,
    input  logic                   ddone,
    output logic                   stall_f,
    output logic                   stall_d,
    output logic                   stall_e,
    output logic                   stall_m,
    output logic                   flush_d,
    output logic                   flush_e,
    output logic                   flush_w,
    output logic                   pc_redirect,
    output logic [63:0]            pc_target,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [0:0] {
        RUN        = 1'b0,
        REDIR_PEND = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [63:0]              pend_tgt_q, pend_tgt_d;
    logic                     ifetched_q, ifetched_d;
    logic [STALL_CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

    logic        dwait_s, lu_s, iwait_s;
    logic        stall_f_s, stall_d_s, stall_e_s, stall_m_s;
    logic        flush_d_s, flush_e_s, flush_w_s, pc_redirect_s;
    logic [63:0] pc_target_s;

    assign dwait_s = dreq & ~ddone;
    assign iwait_s = ireq & ~idone;
    assign lu_s    = ld_e & (ld_dst_e != 5'd0) &
                     ((use1_d & (ra1_d == ld_dst_e)) | (use2_d & (ra2_d == ld_dst_e)));

    // Prioritised hazard decode and next-state for the redirect FSM
    always_comb begin
        stall_f_s     = 1'b0;
        stall_d_s     = 1'b0;
        stall_e_s     = 1'b0;
        stall_m_s     = 1'b0;
        flush_d_s     = 1'b0;
        flush_e_s     = 1'b0;
        flush_w_s     = 1'b0;
        pc_redirect_s = 1'b0;
        pc_target_s   = 64'h0;
        state_d       = state_q;
        pend_tgt_d    = pend_tgt_q;
        ifetched_d    = ifetched_q;
        case (state_q)
            RUN: begin
                if (dwait_s) begin
                    stall_f_s = 1'b1;
                    stall_d_s = 1'b1;
                    stall_e_s = 1'b1;
                    stall_m_s = 1'b1;
                    flush_w_s = 1'b1;
                end else if (lu_s) begin
                    stall_f_s = 1'b1;
                    stall_d_s = 1'b1;
                    flush_e_s = 1'b1;
                end else if (jump_d) begin
                    if (iwait_s) begin
                        // Fetch still busy: park the target, keep bubbling Decode
                        pend_tgt_d = pcsrc_d;
                        state_d    = REDIR_PEND;
                        ifetched_d = 1'b0;
                        stall_f_s  = 1'b1;
                        flush_d_s  = 1'b1;
                    end else begin
                        pc_redirect_s = 1'b1;
                        pc_target_s   = pcsrc_d;
                        flush_d_s     = 1'b1;
                    end
                end else if (iwait_s) begin
                    stall_f_s = 1'b1;
                    flush_d_s = 1'b1;
                end else begin
                    stall_f_s = 1'b0;
                end
            end
            REDIR_PEND: begin
                if (dwait_s) begin
                    stall_f_s = 1'b1;
                    stall_d_s = 1'b1;
                    stall_e_s = 1'b1;
                    stall_m_s = 1'b1;
                    flush_w_s = 1'b1;
                    // Remember a completed fetch so the redirect fires after the dbus wait
                    if (idone) begin
                        ifetched_d = 1'b1;
                    end else begin
                        ifetched_d = ifetched_q;
                    end
                end else if (idone || ifetched_q) begin
                    flush_d_s     = 1'b1;
                    pc_redirect_s = 1'b1;
                    pc_target_s   = pend_tgt_q;
                    state_d       = RUN;
                    ifetched_d    = 1'b0;
                end else if (iwait_s) begin
                    stall_f_s = 1'b1;
                    flush_d_s = 1'b1;
                end else begin
                    stall_f_s = 1'b0;
                end
            end
            default: begin
                state_d    = RUN;
                ifetched_d = 1'b0;
            end
        endcase
    end

    // Saturating stall-cycle counter next value
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_f_s && (stall_cycles_q != {STALL_CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // State, pending target, fetch-seen flag and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= RUN;
            pend_tgt_q     <= 64'h0;
            ifetched_q     <= 1'b0;
            stall_cycles_q <= {STALL_CNT_W{1'b0}};
        end else begin
            state_q        <= state_d;
            pend_tgt_q     <= pend_tgt_d;
            ifetched_q     <= ifetched_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_f      = stall_f_s;
    assign stall_d      = stall_d_s;
    assign stall_e      = stall_e_s;
    assign stall_m      = stall_m_s;
    assign flush_d      = flush_d_s;
    assign flush_e      = flush_e_s;
    assign flush_w      = flush_w_s;
    assign pc_redirect  = pc_redirect_s;
    assign pc_target    = pc_target_s;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core. It takes the decode-stage register addresses and redirect request, the execute-stage load information, and the instruction/data bus handshakes. From these it produces per-stage stall and flush enables plus the next-PC select. It holds a redirect that arrives while the instruction bus is mid-transaction, and counts stall cycles for the performance counter.

## Interface
- Parameters:
- `STALL_CNT_W`, default 32: width of the saturating stall-cycle counter.
- Ports:
- `clk` in 1: core clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ra1_d`, `ra2_d` in 5: source registers of the instruction in Decode.
- `use1_d`, `use2_d` in 1: Decode instruction actually reads `ra1_d` / `ra2_d`.
- `ld_e` in 1: a valid load is in Execute.
- `ld_dst_e` in 5: destination register of that load.
- `jump_d` in 1: Decode requests a redirect.
- `pcsrc_d` in 64: redirect target from Decode.
- `ireq` in 1: fetch bus request outstanding.
- `idone` in 1: fetch data valid this cycle.
- `dreq` in 1: Memory-stage bus request outstanding.
- `ddone` in 1: Memory-stage data valid this cycle.
- `stall_f`, `stall_d`, `stall_e`, `stall_m` out 1: hold the pipeline register feeding F/D/E/M.
- `flush_d`, `flush_e`, `flush_w` out 1: load a bubble into the D/E/W register.
- `pc_redirect` out 1: PC loads `pc_target` next edge.
- `pc_target` out 64: redirect address.
- `stall_cycles` out `STALL_CNT_W`: count of cycles with `stall_f`=1.

## Operation
- Derived signals, evaluated in priority order:
- `dwait` = `dreq` & ~`ddone`.
- `lu` = `ld_e` & `ld_dst_e`≠0 & ((`use1_d` & `ra1_d`==`ld_dst_e`) | (`use2_d` & `ra2_d`==`ld_dst_e`)).
- `iwait` = `ireq` & ~`idone`.
- Priority 1, `dwait`: `stall_f`=`stall_d`=`stall_e`=`stall_m`=1, `flush_w`=1. `jump_d` is ignored; Decode re-presents it after release.
- Priority 2, `lu`: `stall_f`=`stall_d`=1, `flush_e`=1. `jump_d` is ignored, because its operands are not valid yet.
- Priority 3, `jump_d`, pipeline otherwise free:
- If ~`iwait`: `pc_redirect`=1, `pc_target`=`pcsrc_d`, `flush_d`=1.
- If `iwait`: latch `pcsrc_d` into `pend_tgt` and enter REDIR_PEND.
- Priority 4, `iwait`: `stall_f`=1, `flush_d`=1 (bubble into Decode).
- FSM states: RUN and REDIR_PEND. Reset state is RUN.
- RUN to REDIR_PEND: `jump_d` & ~`dwait` & ~`lu` & `iwait`.
- REDIR_PEND behaviour:
- `stall_f`=1 and `flush_d`=1 while `iwait`. `dwait` still dominates.
- On the cycle with `idone`=1, the fetched word is wrong-path: assert `flush_d`=1, `pc_redirect`=1, `pc_target`=`pend_tgt`, and return to RUN.
- New `jump_d` requests are ignored, because Decode holds only bubbles.
- `pc_target` = `pcsrc_d` when `pc_redirect` is from RUN, `pend_tgt` in REDIR_PEND, otherwise 0.
- `stall_cycles`: +1 on every clock with `stall_f`=1. It saturates at all-ones.
- All outputs except `stall_cycles` are combinational from state, `pend_tgt` and inputs.

## Timing
- Reset, asynchronous on `reset`=0:
- State becomes RUN.
- `pend_tgt`=0 and `stall_cycles`=0.
- With all inputs 0, every stall/flush/redirect output is 0 and `pc_target`=0.
- Reset mid-REDIR_PEND discards the pending target.
- Stall and flush take effect at the next rising edge. Zero-cycle decision latency.
- Load-use costs exactly 1 bubble once the load advances. `lu` falls when `ld_e` leaves Execute.
- Redirect from RUN: the PC updates at the next edge, one wrong-path slot flushed.
- Redirect in REDIR_PEND: the PC updates at the edge after `idone`.
- Simultaneous `dwait` & `idone` in REDIR_PEND: state is held. The redirect completes on the first cycle with ~`dwait` after `idone` has been seen; `idone` is latched into `ifetched` and cleared on leaving REDIR_PEND.
- `ld_dst_e`=0 never causes a stall.

## Test plan
- Load-use: `ld_e`=1, `ld_dst_e`=5, `use1_d`=1, `ra1_d`=5 for one cycle -> `stall_f`=`stall_d`=`flush_e`=1 for 1 cycle; `stall_cycles` goes 0→1.
- Load to x0: `ld_dst_e`=0, `ra1_d`=0, `use1_d`=1 -> no stall.
- Free jump: `jump_d`=1, `pcsrc_d`=0x8000_0040, bus idle -> `pc_redirect`=1, `pc_target`=0x8000_0040, `flush_d`=1 that cycle.
- Jump during ifetch: `ireq`=1, `idone`=0 for 3 cycles, `jump_d`=1 with target 0x8000_0100 in cycle 1 -> REDIR_PEND; `stall_f`=1 through cycle 3. In the `idone` cycle, `flush_d`=1, `pc_redirect`=1, `pc_target`=0x8000_0100.
- Dbus wait over load-use: `dreq`=1, `ddone`=0 for 4 cycles plus the `lu` condition -> all four stalls=1 and `flush_w`=1 for 4 cycles, `flush_e`=0. After `ddone`, the load-use bubble follows; `stall_cycles`=5.
- Async reset in REDIR_PEND, then `idone`=1 -> no `pc_redirect`; outputs 0; `stall_cycles`=0.
